// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges the decode load-use stall, the multi-cycle execute
// sequencer and the exception flush into one stall vector plus a redirect.
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PC_W   = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id_i,
    input  logic              mc_start_i,
    input  logic [CNT_W-1:0]  mc_cycles_i,
    input  logic              mc_cancel_i,
    input  logic              flush_req_i,
    input  logic [PC_W-1:0]   flush_pc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic [PC_W-1:0]   new_pc_o,
    output logic              mc_busy_o,
    output logic              mc_done_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    // Stall bit order is {wb,mem,ex,id,if,pc}; EX freezes one stage more than ID.
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MC_RUN = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [5:0]       stall_raw;
    logic             busy_raw;
    logic             done_raw;
    logic             mc_go;

    assign mc_go = mc_start_i && (mc_cycles_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds the number of cycles left including the done cycle, so the
    // op is stalled while cnt > 1 and completes when cnt reaches 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_raw = STALL_NONE;
        busy_raw  = 1'b0;
        done_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (mc_go) begin
                    stall_raw = STALL_EX;
                    state_nxt = MC_RUN;
                    cnt_nxt   = mc_cycles_i;
                end else if (stallreq_id_i) begin
                    stall_raw = STALL_ID;
                end
            end
            MC_RUN: begin
                busy_raw = 1'b1;
                if (cnt > CNT_W'(1)) begin
                    stall_raw = STALL_EX;
                    cnt_nxt   = cnt - CNT_W'(1);
                end else begin
                    if (stallreq_id_i) begin
                        stall_raw = STALL_ID;
                    end
                    done_raw  = !flush_req_i && !mc_cancel_i;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
                if (mc_cancel_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Flush overrides every state and kills any running op.
        if (flush_req_i) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
        end
    end

    assign stall_o   = rst ? STALL_NONE : stall_raw;
    assign mc_busy_o = !rst && busy_raw;
    assign mc_done_o = !rst && done_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_o  <= 1'b0;
            new_pc_o <= '0;
        end else begin
            flush_o <= flush_req_i;
            if (flush_req_i) begin
                new_pc_o <= flush_pc_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if ((stall_o != STALL_NONE) && (stall_cnt_o != {STAT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-timeline model of the stall/flush rules.
module tb_pipe_stall_ctrl;
    localparam int CNT_W  = 6;
    localparam int PC_W   = 32;
    localparam int STAT_W = 4;
    localparam int OBS_W  = 6 + 1 + PC_W + 1 + 1 + STAT_W;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
    localparam logic [5:0] EX = 6'b001111;
    localparam logic [5:0] ID = 6'b000111;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_id_i;
    logic              mc_start_i;
    logic [CNT_W-1:0]  mc_cycles_i;
    logic              mc_cancel_i;
    logic              flush_req_i;
    logic [PC_W-1:0]   flush_pc_i;
    logic [5:0]        stall_o;
    logic              flush_o;
    logic [PC_W-1:0]   new_pc_o;
    logic              mc_busy_o;
    logic              mc_done_o;
    logic [STAT_W-1:0] stall_cnt_o;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .mc_start_i(mc_start_i),
        .mc_cycles_i(mc_cycles_i), .mc_cancel_i(mc_cancel_i), .flush_req_i(flush_req_i),
        .flush_pc_i(flush_pc_i), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o), .stall_cnt_o(stall_cnt_o)
    );

    wire [OBS_W-1:0] obs = {stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, stall_cnt_o};

    int vectors = 0;
    int miscompares = 0;

    // Model: absolute cycle numbers; an op started in cycle N with length K
    // stalls until cycle N+K-1 and reports done in cycle N+K.
    int              cyc;
    bit              m_active;
    int              m_done_cyc;
    bit              m_flush;
    logic [PC_W-1:0] m_pc;
    int              m_stat;
    logic [5:0]      e_stall;
    bit              e_busy;
    bit              e_done;
    logic [OBS_W-1:0] exp_vec;

    always @(posedge clk)
        if (!rst)
            assert (!(mc_start_i && mc_busy_o)) else $error("mc_start_i driven while busy");

    task automatic model_clear();
        cyc = 0; m_active = 0; m_done_cyc = 0; m_flush = 0; m_pc = '0; m_stat = 0;
    endtask

    task automatic drive_idle();
        stallreq_id_i = 0; mc_start_i = 0; mc_cycles_i = '0;
        mc_cancel_i = 0; flush_req_i = 0; flush_pc_i = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        e_stall = 6'b0; e_busy = 0; e_done = 0;
        if (m_flush) begin
            e_stall = 6'b0;
        end else if (m_active) begin
            e_busy = 1;
            if (cyc < m_done_cyc) e_stall = EX;
            else begin
                if (stallreq_id_i) e_stall = ID;
                e_done = !flush_req_i && !mc_cancel_i;
            end
        end else if (mc_start_i && mc_cycles_i != 0) begin
            e_stall = EX;
        end else if (stallreq_id_i) begin
            e_stall = ID;
        end
        exp_vec = {e_stall, m_flush, m_pc, e_busy, e_done, STAT_W'(m_stat)};
    endtask

    task automatic advance();
        @(posedge clk);
        if (flush_req_i) begin
            m_active = 0; m_pc = flush_pc_i;
        end else if (m_flush) begin
            m_active = 0;
        end else if (m_active) begin
            if (mc_cancel_i || cyc >= m_done_cyc) m_active = 0;
        end else if (mc_start_i && mc_cycles_i != 0) begin
            m_active = 1; m_done_cyc = cyc + int'(mc_cycles_i);
        end
        m_flush = flush_req_i;
        if (e_stall != 0 && m_stat < STAT_MAX) m_stat++;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1; drive_idle(); model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        sample(); vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_idle got=%h want=0", obs); end
        advance();
        for (int i = 0; i < 4; i++) begin
            mc_start_i = (i == 0); mc_cycles_i = (i == 0) ? 6'd8 : 6'd0;
            sample(); vectors++;
            if (obs !== exp_vec) begin miscompares++; $display("FAIL reset_run c=%0d got=%h want=%h", i, obs, exp_vec); end
            advance();
        end
        drive_idle();
        stallreq_id_i = 1;
        rst = 1; #1; vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_async got=%h want=0", obs); end
        repeat (2) @(posedge clk);
        stallreq_id_i = 0; model_clear();
        #1 rst = 0;
        sample(); vectors++;
        if (obs !== '0 || obs !== exp_vec) begin miscompares++; $display("FAIL reset_release got=%h want=0", obs); end
        advance();
    endtask

    task automatic test_id_hazard();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            stallreq_id_i = (i < 2);
            sample(); vectors++;
            if (obs !== exp_vec || stall_o !== ((i < 2) ? ID : 6'b0)) begin
                miscompares++; $display("FAIL id_hazard c=%0d got=%h want=%h", i, obs, exp_vec);
            end
            advance();
        end
        vectors++;
        if (stall_cnt_o !== STAT_W'(2)) begin miscompares++; $display("FAIL id_stat got=%0d want=2", stall_cnt_o); end
    endtask

    task automatic test_multicycle();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            mc_start_i = (i == 0 || i == 5);
            mc_cycles_i = (i == 0) ? 6'd4 : 6'd0;
            stallreq_id_i = (i == 4);
            sample(); vectors++;
            if (obs !== exp_vec || stall_o !== ((i < 4) ? EX : (i == 4) ? ID : 6'b0)
                || mc_done_o !== (i == 4) || mc_busy_o !== (i >= 1 && i <= 4)) begin
                miscompares++; $display("FAIL multicycle c=%0d got=%h want=%h", i, obs, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_flush_abort();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_idle();
            mc_start_i = (i == 0); mc_cycles_i = (i == 0) ? 6'd10 : 6'd0;
            flush_req_i = (i == 3); flush_pc_i = (i == 3) ? 32'h0000_0100 : 32'h0;
            stallreq_id_i = (i == 4);
            sample(); vectors++;
            if (obs !== exp_vec || (i == 4 && (flush_o !== 1'b1 || new_pc_o !== 32'h100
                || stall_o !== 6'b0 || mc_done_o !== 1'b0))
                || (i >= 5 && (mc_busy_o !== 1'b0 || flush_o !== 1'b0))) begin
                miscompares++; $display("FAIL flush_abort c=%0d got=%h want=%h", i, obs, exp_vec);
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] want_pc [4];
        logic            want_fl [4];
        want_pc = '{32'h0, 32'h20, 32'h40, 32'h40};
        want_fl = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            flush_req_i = (i < 2); flush_pc_i = (i == 0) ? 32'h20 : (i == 1) ? 32'h40 : 32'h0;
            sample(); vectors++;
            if (obs !== exp_vec || flush_o !== want_fl[i] || new_pc_o !== want_pc[i]) begin
                miscompares++; $display("FAIL back_to_back c=%0d got=%h want=%h", i, obs, exp_vec);
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_cancel();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mc_start_i = (i == 0); mc_cycles_i = (i == 0) ? 6'd6 : 6'd0;
            mc_cancel_i = (i == 2);
            sample(); vectors++;
            if (obs !== exp_vec || mc_done_o !== 1'b0 || (i >= 3 && mc_busy_o !== 1'b0)
                || (i == 2 && stall_o !== EX)) begin
                miscompares++; $display("FAIL cancel c=%0d got=%h want=%h", i, obs, exp_vec);
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            stallreq_id_i = (i < 20);
            sample(); vectors++;
            if (obs !== exp_vec) begin miscompares++; $display("FAIL saturation c=%0d got=%h want=%h", i, obs, exp_vec); end
            advance();
        end
        vectors++;
        if (stall_cnt_o !== 4'hF) begin miscompares++; $display("FAIL sat_final got=%h want=f", stall_cnt_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            stallreq_id_i = ($urandom_range(0, 2) == 0);
            flush_req_i   = ($urandom_range(0, 19) == 0);
            flush_pc_i    = $urandom;
            mc_cancel_i   = ($urandom_range(0, 14) == 0);
            mc_start_i    = !m_active && ($urandom_range(0, 3) == 0);
            mc_cycles_i   = CNT_W'($urandom_range(0, 12));
            if (i % 97 == 50) mc_cycles_i = 6'd63;
            sample(); vectors++;
            if (obs !== exp_vec) begin miscompares++; $display("FAIL random c=%0d got=%h want=%h", i, obs, exp_vec); end
            advance();
        end
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; drive_idle(); model_clear();
        test_reset();
        test_id_hazard();
        test_multicycle();
        test_flush_abort();
        test_back_to_back();
        test_cancel();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges the decode-stage load-use stall request with a multi-cycle execute-op sequencer and an exception flush path. It produces the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the flush/redirect to pc_reg. It also keeps a saturating stall-cycle statistics counter.

Parameters:
CNT_W, 6, width of the multi-cycle length field and internal down-counter
PC_W, 32, width of redirect address
STAT_W, 32, width of stall statistics counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
stallreq_id_i  in  1  decode hazard stall request (combinational from decode)
mc_start_i  in  1  execute begins a multi-cycle op this cycle (combinational from execute)
mc_cycles_i  in  CNT_W  op length K in cycles, valid with mc_start_i
mc_cancel_i  in  1  abort running multi-cycle op
flush_req_i  in  1  exception/flush request
flush_pc_i  in  PC_W  redirect target, valid with flush_req_i
stall_o  out  6  {wb,mem,ex,id,if,pc} stall, bit0 = pc
flush_o  out  1  flush all pipeline registers, registered
new_pc_o  out  PC_W  redirect address, registered
mc_busy_o  out  1  multi-cycle op in progress
mc_done_o  out  1  final cycle of multi-cycle op; execute muxes result
stall_cnt_o  out  STAT_W  cycles with stall_o != 0, saturating

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. While rst=1 all outputs are 0, the state is IDLE, and cnt and stall_cnt are 0. Combinational outputs are also forced to 0.
- States: IDLE, MC_RUN, FLUSH. Internal cnt[CNT_W-1:0].
- Stall encodings: EX stall = 6'b001111. ID stall = 6'b000111. None = 6'b000000.
- IDLE:
  - mc_start_i=1 with K!=0: stall_o=EX this cycle; next edge cnt<=K, state<=MC_RUN.
  - mc_start_i=1 with K=0: ignored (single-cycle op); no stall, no done.
  - Otherwise: stall_o=ID if stallreq_id_i, else none.
- MC_RUN:
  - mc_busy_o=1.
  - cnt>1: stall_o=EX; cnt decrements each edge.
  - cnt==1: stall_o=none, mc_done_o=1 (suppressed if flush_req_i=1); next edge state<=IDLE.
  - Total: op started in cycle N stalls cycles N..N+K-1, and mc_done_o is high in cycle N+K.
  - stallreq_id_i is ignored while stall_o=EX, because EX dominates ID. On the done cycle, ID applies if requested.
  - mc_start_i in MC_RUN is illegal; it is ignored and flagged by a bench assertion.
  - mc_cancel_i=1: next edge state<=IDLE, cnt<=0, no mc_done_o. The current cycle's stall_o is unchanged.
- Flush has the highest priority in every state:
  - flush_req_i sampled at an edge sets state<=FLUSH, flush_o<=1, new_pc_o<=flush_pc_i, and cnt<=0.
  - Any multi-cycle op is aborted without done.
- FLUSH (one cycle):
  - flush_o=1, stall_o=none; all requests ignored except flush_req_i.
  - flush_req_i again: stay in FLUSH, flush_o stays 1, new_pc_o reloads.
  - Else next edge: flush_o<=0, state<=IDLE.
  - new_pc_o holds its last value after flush_o drops.
- stall_cnt_o increments on each edge where stall_o!=0, and saturates at all-ones.
- Simultaneous mc_start_i and stallreq_id_i in IDLE: EX stall wins and the sequencer starts.

Test Plan:
- Reset: assert rst mid-MC_RUN (cnt=5) -> all outputs 0 immediately; after release, IDLE, stall_o=0, stall_cnt_o=0.
- ID hazard: stallreq_id_i=1 for 2 cycles in IDLE -> stall_o=6'b000111 both cycles, then 0; stall_cnt_o=2.
- Multi-cycle: mc_start_i with K=4 at cycle N -> stall_o=6'b001111 in N..N+3, mc_done_o=1 only in N+4, mc_busy_o=1 in N+1..N+4; K=0 -> no stall, no done.
- Cancel/flush abort: K=10 running, flush_req_i=1 with flush_pc_i=32'h0000_0100 at cycle 3 -> next cycle flush_o=1, new_pc_o=32'h100, stall_o=0, no mc_done_o, then IDLE.
- Back-to-back flush: flush_req_i on two consecutive cycles with pc 32'h20 then 32'h40 -> flush_o high 2 cycles, new_pc_o=32'h20 then 32'h40.
- Saturation: STAT_W=4, hold stallreq_id_i for 20 cycles -> stall_cnt_o stops at 4'hF.
